// File: rtl/lsu_pipelined.sv
// Load/store unit with an in-order tracker allowing several outstanding OBI data
// requests. It formats load data, rejects misaligned or illegal accesses locally,
// and flags peripheral-window addresses.
module lsu_pipelined #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] MEM_OFFSET      = 32'h0,
   parameter logic [31:0] PERIPH_MIN      = 32'h0000_0600,
   parameter logic [31:0] PERIPH_MAX      = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        in_range_periph,
   output logic        idle,
   output logic        protocol_err,
   output logic        data_req_o,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   typedef struct packed {
      logic       we;
      logic [2:0] op;
      logic [1:0] off;
   } trk_t;

   trk_t             trk_q [MAX_OUTSTANDING];
   trk_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             err_pending;

   logic        op_ok;
   logic        aligned;
   logic        legal;
   logic        empty;
   logic        issue;
   logic        err_accept;
   logic        push;
   logic        pop;
   logic [31:0] bus_addr;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Decode: funct3 validity for the direction and natural alignment
   always_comb begin
      op_ok   = 1'b0;
      aligned = 1'b1;
      case (req_op)
         3'b000, 3'b001, 3'b010: op_ok = 1'b1;
         3'b100, 3'b101:         op_ok = ~req_we;
         default:                op_ok = 1'b0;
      endcase
      case (req_op[1:0])
         2'b01:   aligned = ~req_addr[0];
         2'b10:   aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   assign legal      = op_ok & aligned;
   assign empty      = (count == '0);
   assign issue      = reset_n & req_valid & legal & ~flush & (count < MAX_CNT) & ~err_pending;
   assign err_accept = reset_n & req_valid & ~legal & empty & ~err_pending & ~flush;
   assign push       = issue & data_gnt_i;
   assign pop        = data_rvalid_i & ~empty;
   assign req_ready  = push | err_accept;
   assign bus_addr   = req_addr - MEM_OFFSET;
   assign head       = trk_q[rd_ptr];

   assign in_range_periph = (req_addr >= PERIPH_MIN) && (req_addr < PERIPH_MAX);
   assign idle            = empty & ~err_pending;
   assign resp_valid      = pop | err_pending;
   assign resp_err        = err_pending;

   // Bus request: lane steering for stores, everything quiet when not issuing
   always_comb begin
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_addr_o  = 32'h0;
      data_be_o    = 4'h0;
      data_wdata_o = 32'h0;
      if (issue) begin
         data_req_o  = 1'b1;
         data_we_o   = req_we;
         data_addr_o = bus_addr & 32'hFFFF_FFFC;
         data_be_o   = 4'hF;
         if (req_we) begin
            case (req_op[1:0])
               2'b00: begin
                  data_be_o    = 4'b0001 << req_addr[1:0];
                  data_wdata_o = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
               end
               2'b01: begin
                  data_be_o    = req_addr[1] ? 4'b1100 : 4'b0011;
                  data_wdata_o = req_addr[1] ? {req_wdata[15:0], 16'h0} : {16'h0, req_wdata[15:0]};
               end
               default: data_wdata_o = req_wdata;
            endcase
         end
      end
   end

   // Load formatting from the oldest tracker entry
   always_comb begin
      rbyte      = 8'h0;
      rhalf      = head.off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
      resp_rdata = 32'h0;
      case (head.off)
         2'b00:   rbyte = data_rdata_i[7:0];
         2'b01:   rbyte = data_rdata_i[15:8];
         2'b10:   rbyte = data_rdata_i[23:16];
         default: rbyte = data_rdata_i[31:24];
      endcase
      if (pop && !head.we) begin
         case (head.op)
            3'b000:  resp_rdata = {{24{rbyte[7]}}, rbyte};
            3'b001:  resp_rdata = {{16{rhalf[15]}}, rhalf};
            3'b010:  resp_rdata = data_rdata_i;
            3'b100:  resp_rdata = {24'h0, rbyte};
            3'b101:  resp_rdata = {16'h0, rhalf};
            default: resp_rdata = 32'h0;
         endcase
      end
   end

   // Tracker FIFO, occupancy, error and protocol flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) trk_q[i] <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         err_pending  <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (push) begin
            trk_q[wr_ptr] <= trk_t'{we: req_we, op: req_op, off: req_addr[1:0]};
            wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         err_pending  <= err_accept;
         protocol_err <= protocol_err | (data_rvalid_i & empty);
      end
   end

endmodule
